store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Write buffer that sits directly downstream of the write-through data cache, between the cache's memory interface and data memory (BRAM).
- Absorbs the cache's full-word write-backs into a small FIFO so store hits do not wait on memory, and drains them to memory in order.
- Gives cache-miss reads priority on the memory port, and forwards buffered data so a miss refill never returns stale memory contents.

Parameters:
DEPTH, 4, number of buffered word entries; must be a power of 2 and at least 2
AW, 32, address width
DW, 32, data width; the buffer only ever holds full, already-merged words

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-low reset
wb_valid  in  1  cache write-back request (the cache's write strobe)
wb_addr  in  AW  write-back word address; bits [1:0] are ignored
wb_data  in  DW  merged write data
wb_ready  out  1  write-back accepted this cycle
wb_stall  out  1  wb_valid & ~wb_ready; OR'd into the data-stall signal
rd_req  in  1  cache miss read in progress (miss or update state)
rd_addr  in  AW  miss read address
fwd_hit  out  1  a buffered entry matches rd_addr[AW-1:2]
fwd_data  out  DW  data of the youngest matching entry
mem_addr  out  AW  drain address (word aligned)
mem_wdata  out  DW  drain data
mem_we  out  1  drain write request
mem_ready  in  1  memory accepts the write this cycle
drain_req  in  1  force drain and block new entries (fence or MMIO access)
empty  out  1  count == 0
count  out  clog2(DEPTH)+1  occupancy

Behaviour:
- Storage: DEPTH entries of {valid, addr[AW-1:2], data}, with head and tail pointers that wrap modulo DEPTH, plus an occupancy count.
- Reset (rst==0 at a clock edge):
  - count=0, head=tail=0, all valid bits cleared.
  - Outputs: mem_we=0, empty=1, wb_ready=1, fwd_hit=0, fwd_data=0.
  - Reset in the middle of a drain discards all pending entries.
- Drain request (combinational):
  - mem_we = ~empty & (~rd_req | full | drain_req).
  - mem_addr = {head.addr, 2'b00}; mem_wdata = head.data.
  - deq = mem_we & mem_ready. The head retires at the clock edge where deq is high.
  - mem_addr and mem_wdata stay stable while mem_we is high and mem_ready is low.
- Read priority: when rd_req is high and the buffer is neither full nor under drain_req, draining pauses so the cache owns the memory port.
- Coalesce:
  - coal = wb_valid & ~empty & (youngest entry addr == wb_addr[AW-1:2]) & ~(deq & count==1).
  - On coal, the youngest entry's data is overwritten in place; count is unchanged.
- Enqueue:
  - wb_ready = ~drain_req & (coal | ~full | deq).
  - Accepted writes (wb_valid & wb_ready & ~coal) are written at tail; tail advances.
  - Full with a same-cycle dequeue: the enqueue is accepted and count stays at DEPTH.
- Count update: count_next = count + enq - deq, where enq excludes coalesced writes.
- Forwarding:
  - Combinational search over valid entries, youngest first.
  - fwd_hit=1 and fwd_data=entry.data for the first match; otherwise fwd_hit=0 and fwd_data=0.
  - A write arriving on wb_* in the same cycle is not forwarded.
  - The head being dequeued in the same cycle is still forwarded, because the memory write has not landed yet.
- Cache refill: the cache substitutes fwd_data for the memory data when fwd_hit is high.
- drain_req: draining continues until empty=1, and new entries are blocked (wb_stall asserts on wb_valid) for as long as drain_req is high.
- Latency: an accepted store becomes visible in memory no earlier than 1 cycle after acceptance.

Decomposition:
- Shared constants package: entry struct field widths (word-address width AW-2) and STB_DEPTH default.
- Single sub-module stb_fwd_match: combinational youngest-first match and priority select over the entry array, driven by head, tail and count.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release → empty=1, count=0, mem_we=0, wb_ready=1.
- Basic store: write 0x100/0xDEADBEEF, then 0x104/0x11111111 with mem_ready=1 → mem_we asserts with 0x100 and then 0x104, in order; empty=1 after 2 drains.
- Backpressure: mem_ready=0, 5 distinct writes → count reaches 4; 5th write sees wb_stall=1. Raise mem_ready → 5th write is accepted in the same cycle the head dequeues.
- Coalesce: writes to 0x200 with data 0xA then 0xB, back to back, mem_ready=0 → count=1; after mem_ready=1 one drain with 0xB.
- Read priority and forward: buffer holds 0x300/0x55 (older) and 0x300/0x66 (younger, other entry in between); rd_req=1, rd_addr=0x302 → fwd_hit=1, fwd_data=0x66, mem_we=0 while not full.
- drain_req: 3 entries, drain_req=1 with rd_req=1 → drains ignore rd_req, wb_valid is stalled, empty=1 after 3 accepted cycles. Also rst=0 mid-drain → count=0 next cycle.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared constants for the store buffer: default geometry and entry layout.
package store_buffer_pkg;

  localparam int STB_DEPTH = 4;
  localparam int STB_AW    = 32;
  localparam int STB_DW    = 32;
  // Entries hold word addresses only; the byte offset is always zero.
  localparam int STB_WAW   = STB_AW - 2;

  typedef struct packed {
    logic               valid;
    logic [STB_WAW-1:0] addr;
    logic [STB_DW-1:0]  data;
  } stb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Cache-side, memory-side and status signals of the store buffer.
// master = the cache/memory environment, slave = the store buffer itself.
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int AW    = STB_AW,
  parameter int DW    = STB_DW,
  parameter int DEPTH = STB_DEPTH
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          wb_ready;
  logic          wb_stall;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_ready;
  logic          drain_req;
  logic          empty;
  logic [CW-1:0] count;

  modport master (
    output wb_valid, wb_addr, wb_data, rd_req, rd_addr, mem_ready, drain_req,
    input  wb_ready, wb_stall, fwd_hit, fwd_data, mem_addr, mem_wdata, mem_we,
           empty, count
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, rd_req, rd_addr, mem_ready, drain_req,
    output wb_ready, wb_stall, fwd_hit, fwd_data, mem_addr, mem_wdata, mem_we,
           empty, count
  );

endinterface

// File: rtl/store_buffer_fwd_match.sv
// Youngest-first address match over the buffered entries, used to forward
// pending store data to a cache miss refill.
module stb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = STB_DEPTH,
  parameter int WAW   = STB_WAW,
  parameter int DW    = STB_DW,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
)
(
  input  logic [DEPTH-1:0] valid,
  input  logic [WAW-1:0]   addr [DEPTH],
  input  logic [DW-1:0]    data [DEPTH],
  input  logic [PW-1:0]    head,
  input  logic [PW-1:0]    tail,
  input  logic [CW-1:0]    count,
  input  logic [WAW-1:0]   rd_word,
  output logic             hit,
  output logic [DW-1:0]    hit_data
);

  logic [PW-1:0] idx_s;
  logic          match_s;
  logic          unused_head_s;

  // head is implied by tail and count; kept on the port for clarity of intent.
  assign unused_head_s = ^head;

  // Walk from the youngest entry (tail-1) backwards; the first match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx_s    = tail;
    match_s  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx_s    = tail - PW'(i + 1);
      match_s  = ~hit & (CW'(i) < count) & valid[idx_s] & (addr[idx_s] == rd_word);
      hit_data = match_s ? data[idx_s] : hit_data;
      hit      = hit | match_s;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Write buffer between the write-through data cache and data memory.
// Absorbs full-word write-backs, coalesces back-to-back writes to the same
// word, drains in order, yields the memory port to miss reads and forwards
// pending data to refills.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = STB_DEPTH,
  parameter int AW    = STB_AW,
  parameter int DW    = STB_DW
)
(
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave bus
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int WAW = AW - 2;

  logic [DEPTH-1:0] valid_r;
  logic [WAW-1:0]   addr_r [DEPTH];
  logic [DW-1:0]    data_r [DEPTH];
  logic [PW-1:0]    head_r;
  logic [PW-1:0]    tail_r;
  logic [CW-1:0]    count_r;

  logic [CW-1:0]    count_next_s;
  logic [PW-1:0]    young_s;
  logic [WAW-1:0]   wb_word_s;
  logic [WAW-1:0]   rd_word_s;
  logic             empty_s;
  logic             full_s;
  logic             mem_we_s;
  logic             deq_s;
  logic             coal_s;
  logic             wb_ready_s;
  logic             enq_s;
  logic             coal_wr_s;
  logic             fwd_hit_s;
  logic [DW-1:0]    fwd_data_s;
  logic             unused_addr_lsb_s;

  assign wb_word_s         = bus.wb_addr[AW-1:2];
  assign rd_word_s         = bus.rd_addr[AW-1:2];
  assign unused_addr_lsb_s = ^{bus.wb_addr[1:0], bus.rd_addr[1:0]};

  // Drain, coalesce and accept decisions for the current cycle.
  always_comb begin
    empty_s   = (count_r == CW'(0));
    full_s    = (count_r == CW'(DEPTH));
    young_s   = tail_r - PW'(1);
    // A miss read owns the memory port unless the buffer is full or a fence
    // forces it empty.
    mem_we_s  = ~empty_s & (~bus.rd_req | full_s | bus.drain_req);
    deq_s     = mem_we_s & bus.mem_ready;
    // Never merge into an entry that is leaving this cycle.
    coal_s    = bus.wb_valid & ~empty_s & (addr_r[young_s] == wb_word_s) &
                ~(deq_s & (count_r == CW'(1)));
    wb_ready_s = ~bus.drain_req & (coal_s | ~full_s | deq_s);
    // A stalled write is repeated by the cache, so only accepted ones merge.
    coal_wr_s  = coal_s & wb_ready_s;
    enq_s      = bus.wb_valid & wb_ready_s & ~coal_s;
    count_next_s = count_r + CW'(enq_s) - CW'(deq_s);
  end

  // Entry storage, pointers and occupancy; reset discards any pending entries.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      valid_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i] <= '0;
        data_r[i] <= '0;
      end
    end else begin
      if (deq_s) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= head_r + PW'(1);
      end
      // When full with a dequeue, tail equals head; the new entry wins.
      if (enq_s) begin
        valid_r[tail_r] <= 1'b1;
        addr_r[tail_r]  <= wb_word_s;
        data_r[tail_r]  <= bus.wb_data;
        tail_r          <= tail_r + PW'(1);
      end
      if (coal_wr_s) begin
        data_r[young_s] <= bus.wb_data;
      end
      count_r <= count_next_s;
    end
  end

  stb_fwd_match #(
    .DEPTH (DEPTH),
    .WAW   (WAW),
    .DW    (DW)
  ) u_fwd_match (
    .valid    (valid_r),
    .addr     (addr_r),
    .data     (data_r),
    .head     (head_r),
    .tail     (tail_r),
    .count    (count_r),
    .rd_word  (rd_word_s),
    .hit      (fwd_hit_s),
    .hit_data (fwd_data_s)
  );

  assign bus.wb_ready  = wb_ready_s;
  assign bus.wb_stall  = bus.wb_valid & ~wb_ready_s;
  assign bus.mem_we    = mem_we_s;
  assign bus.mem_addr  = {addr_r[head_r], 2'b00};
  assign bus.mem_wdata = data_r[head_r];
  assign bus.fwd_hit   = fwd_hit_s;
  assign bus.fwd_data  = fwd_data_s;
  assign bus.empty     = empty_s;
  assign bus.count     = count_r;

endmodule

// File: tb/tb_store_buffer.sv
// Directed, table-driven bench for store_buffer with hand-computed
// expectations, plus hand-written reset and mid-drain reset sequences.
module tb_store_buffer;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  store_buffer_if #(.AW(32), .DW(32), .DEPTH(4)) bus ();

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        wv;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        rr;
    logic [31:0] ra;
    logic        mr;
    logic        dr;
    logic        e_wrdy;
    logic        e_we;
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;
    logic        e_fhit;
    logic [31:0] e_fdata;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(
    input logic wv, input logic [31:0] wa, input logic [31:0] wd,
    input logic rr, input logic [31:0] ra, input logic mr, input logic dr,
    input logic e_wrdy, input logic e_we, input logic [31:0] e_maddr,
    input logic [31:0] e_mwdata, input logic e_fhit, input logic [31:0] e_fdata,
    input logic [2:0] e_cnt);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wd = wd; v.rr = rr; v.ra = ra; v.mr = mr; v.dr = dr;
    v.e_wrdy = e_wrdy; v.e_we = e_we; v.e_maddr = e_maddr; v.e_mwdata = e_mwdata;
    v.e_fhit = e_fhit; v.e_fdata = e_fdata; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [31:0] wa, input logic [31:0] wd,
                       input logic rr, input logic [31:0] ra, input logic mr,
                       input logic dr);
    bus.wb_valid  = wv;
    bus.wb_addr   = wa;
    bus.wb_data   = wd;
    bus.rd_req    = rr;
    bus.rd_addr   = ra;
    bus.mem_ready = mr;
    bus.drain_req = dr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           wv    wa            wd            rr    ra            mr    dr    wrdy  we    maddr         mwdata        fhit  fdata         cnt
    // basic store, in-order drain
    vecs.push_back(mk(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 3'd0));
    vecs.push_back(mk(1'b1, 32'h0000_0104, 32'h1111_1111, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0, 3'd1));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0104, 32'h1111_1111, 1'b0, 32'h0, 3'd1));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 3'd0));
    // backpressure: fill, stall the fifth write, then accept it on a dequeue
    vecs.push_back(mk(1'b1, 32'h0000_0400, 32'h1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 3'd0));
    vecs.push_back(mk(1'b1, 32'h0000_0404, 32'h2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'h1, 1'b0, 32'h0, 3'd1));
    vecs.push_back(mk(1'b1, 32'h0000_0408, 32'h3, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'h1, 1'b0, 32'h0, 3'd2));
    vecs.push_back(mk(1'b1, 32'h0000_040C, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'h1, 1'b0, 32'h0, 3'd3));
    vecs.push_back(mk(1'b1, 32'h0000_0410, 32'h5, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0400, 32'h1, 1'b0, 32'h0, 3'd4));
    vecs.push_back(mk(1'b1, 32'h0000_0410, 32'h5, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'h1, 1'b0, 32'h0, 3'd4));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0404, 32'h2, 1'b0, 32'h0, 3'd4));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0408, 32'h3, 1'b0, 32'h0, 3'd3));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_040C, 32'h4, 1'b0, 32'h0, 3'd2));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0410, 32'h5, 1'b0, 32'h0, 3'd1));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 3'd0));
    // coalesce, forward of merged data, no merge into a retiring single entry
    vecs.push_back(mk(1'b1, 32'h0000_0200, 32'hA, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 3'd0));
    vecs.push_back(mk(1'b1, 32'h0000_0200, 32'hB, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'hA, 1'b0, 32'h0, 3'd1));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0201, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'hB, 3'd1));
    vecs.push_back(mk(1'b1, 32'h0000_0200, 32'hC, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'hB, 1'b0, 32'h0, 3'd1));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'hC, 1'b0, 32'h0, 3'd1));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 3'd0));
    // read priority and youngest-first forwarding
    vecs.push_back(mk(1'b1, 32'h0000_0300, 32'h55, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 3'd0));
    vecs.push_back(mk(1'b1, 32'h0000_0500, 32'h77, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h55, 1'b0, 32'h0, 3'd1));
    vecs.push_back(mk(1'b1, 32'h0000_0300, 32'h66, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h55, 1'b0, 32'h0, 3'd2));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0302, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h66, 3'd3));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0500, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h77, 3'd3));
    vecs.push_back(mk(1'b1, 32'h0000_0700, 32'h99, 1'b1, 32'h0000_0700, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 3'd3));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0700, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h55, 1'b1, 32'h99, 3'd4));
    // drain_req overrides read priority, blocks writes, head still forwarded
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0500, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0500, 32'h77, 1'b1, 32'h77, 3'd3));
    vecs.push_back(mk(1'b1, 32'h0000_0800, 32'h88, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h66, 1'b0, 32'h0, 3'd2));
    vecs.push_back(mk(1'b1, 32'h0000_0800, 32'h88, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0700, 32'h99, 1'b0, 32'h0, 3'd1));
    vecs.push_back(mk(1'b1, 32'h0000_0800, 32'h88, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0700, 32'h99, 1'b0, 32'h0, 3'd1));
    vecs.push_back(mk(1'b1, 32'h0000_0800, 32'h88, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 3'd0));
    vecs.push_back(mk(1'b1, 32'h0000_0800, 32'h88, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 3'd0));

    // Reset held for two cycles.
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    chk("reset.empty",    32'(bus.empty),    32'h1);
    chk("reset.count",    32'(bus.count),    32'h0);
    chk("reset.mem_we",   32'(bus.mem_we),   32'h0);
    chk("reset.wb_ready", 32'(bus.wb_ready), 32'h1);
    chk("reset.fwd_hit",  32'(bus.fwd_hit),  32'h0);
    chk("reset.fwd_data", bus.fwd_data,      32'h0);
    tick();

    // Table: drive, settle, compare pre-edge outputs, then clock.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].rr, vecs[i].ra,
            vecs[i].mr, vecs[i].dr);
      #2;
      chk($sformatf("v%0d.wb_ready", i), 32'(bus.wb_ready), 32'(vecs[i].e_wrdy));
      chk($sformatf("v%0d.wb_stall", i), 32'(bus.wb_stall),
          32'(vecs[i].wv & ~vecs[i].e_wrdy));
      chk($sformatf("v%0d.mem_we", i),   32'(bus.mem_we),   32'(vecs[i].e_we));
      if (vecs[i].e_we) begin
        chk($sformatf("v%0d.mem_addr", i),  bus.mem_addr,  vecs[i].e_maddr);
        chk($sformatf("v%0d.mem_wdata", i), bus.mem_wdata, vecs[i].e_mwdata);
      end
      chk($sformatf("v%0d.fwd_hit", i),  32'(bus.fwd_hit), 32'(vecs[i].e_fhit));
      chk($sformatf("v%0d.fwd_data", i), bus.fwd_data,     vecs[i].e_fdata);
      chk($sformatf("v%0d.count", i),    32'(bus.count),   32'(vecs[i].e_cnt));
      chk($sformatf("v%0d.empty", i),    32'(bus.empty),   32'(vecs[i].e_cnt == 3'd0));
      tick();
    end

    // Mid-drain reset: build three entries, drain one, then reset.
    drive(1'b1, 32'h0000_0804, 32'h1, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0000_0808, 32'h2, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    #2;
    chk("mdr.count_before", 32'(bus.count),  32'h3);
    chk("mdr.mem_we",       32'(bus.mem_we), 32'h1);
    chk("mdr.mem_addr",     bus.mem_addr,    32'h0000_0800);
    tick();
    chk("mdr.count_mid",    32'(bus.count),  32'h2);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0804, 1'b0, 1'b0);
    #2;
    chk("mdr.count_after",  32'(bus.count),    32'h0);
    chk("mdr.empty_after",  32'(bus.empty),    32'h1);
    chk("mdr.mem_we_after", 32'(bus.mem_we),   32'h0);
    chk("mdr.wb_ready",     32'(bus.wb_ready), 32'h1);
    chk("mdr.fwd_hit",      32'(bus.fwd_hit),  32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
